// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer.
// Frame length depends on BIT_SERIALIZER_PARITY_EN (adds one even-parity bit when defined).
package bit_serializer_pkg;

    localparam int DATA_W_MAX = 32;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    function automatic int frame_len(input int data_w);
`ifdef BIT_SERIALIZER_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: DATA_W-bit words in over valid/ready, one bit per clock out, MSB first.
// Optional trailing even-parity bit when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int FRAME_LEN = frame_len(DATA_W);
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [DATA_W-1:0] word);
`ifdef BIT_SERIALIZER_PARITY_EN
        return {word, ^word};
`else
        return word;
`endif
    endfunction

    ser_state_t           r_state;
    ser_state_t           w_next_state;
    logic [FRAME_LEN-1:0] r_sr;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATA_W-1:0]    r_hold;
    logic                 r_hold_full;

    logic                 w_xfer;
    logic                 w_last;
    logic                 w_load;
    logic [DATA_W-1:0]    w_load_word;

    // in_ready comes only from the registered flag, so a transfer never coincides with a full hold.
    assign w_xfer      = in_valid && !r_hold_full;
    assign w_last      = (r_state == SER_SHIFT) && (r_cnt == LAST_CNT);
    assign w_load      = ((r_state == SER_IDLE) || w_last) && (r_hold_full || w_xfer);
    assign w_load_word = r_hold_full ? r_hold : in_data;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SER_IDLE:  if (w_load) w_next_state = SER_SHIFT;
            SER_SHIFT: if (w_last && !w_load) w_next_state = SER_IDLE;
            default:   w_next_state = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SER_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_load) begin
                r_sr  <= build_frame(w_load_word);
                r_cnt <= '0;
            end else if (r_state == SER_SHIFT) begin
                r_sr  <= {r_sr[FRAME_LEN-2:0], 1'b0};
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end

            // A transferred word goes straight to the shifter when a load slot is open, else it parks in hold.
            if (w_xfer && !w_load) begin
                r_hold      <= in_data;
                r_hold_full <= 1'b1;
            end else if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign in_ready    = !r_hold_full;
    assign bit_valid   = (r_state == SER_SHIFT);
    assign bit_out     = (r_state == SER_SHIFT) && r_sr[FRAME_LEN-1];
    assign frame_start = (r_state == SER_SHIFT) && (r_cnt == '0);
    assign busy        = (r_state == SER_SHIFT) || r_hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: directed scenarios plus a random stream, checked against a bit-queue model.
// The model holds every not-yet-emitted frame bit in order; all expected outputs derive from its size and head.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       bit_out;
    logic       bit_valid;
    logic       frame_start;
    logic       busy;

    int vectors = 0;
    int errs    = 0;
    logic q[$];
    logic last_xfer;

    bit_serializer #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ready();
        return q.size() <= FL;
    endfunction

    task automatic check_all(input string ctx);
        logic has;
        has = (q.size() > 0);
        chk({ctx, ".bit_valid"},   bit_valid,   has);
        chk({ctx, ".bit_out"},     bit_out,     has ? q[0] : 1'b0);
        chk({ctx, ".frame_start"}, frame_start, has && (q.size() % FL == 0));
        chk({ctx, ".in_ready"},    in_ready,    exp_ready());
        chk({ctx, ".busy"},        busy,        has);
    endtask

    function automatic void push_frame(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) q.push_back(w[i]);
`ifdef BIT_SERIALIZER_PARITY_EN
        q.push_back(^w);
`endif
    endfunction

    // Called at a falling edge: check, drive, advance one clock, update the model, return at the next falling edge.
    task automatic cycle(input string ctx, input logic v, input logic [7:0] d);
        logic xfer;
        check_all(ctx);
        in_valid = v;
        in_data  = d;
        xfer = v && exp_ready();
        @(posedge clk);
        if (q.size() > 0) void'(q.pop_front());
        if (xfer) push_frame(d);
        last_xfer = xfer;
        @(negedge clk);
    endtask

    task automatic send_words(input string ctx, input logic [7:0] w[]);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < w.size() && guard < 200) begin
            cycle(ctx, 1'b1, w[idx]);
            if (last_xfer) idx++;
            guard++;
        end
        if (idx < w.size()) begin
            vectors++;
            errs++;
            $error("FAIL %s.accept_timeout observed=%0d expected=%0d", ctx, idx, w.size());
        end
    endtask

    task automatic drain(input string ctx, input int n);
        for (int i = 0; i < n; i++) cycle(ctx, 1'b0, 8'($urandom));
    endtask

    initial begin
        logic [7:0] words[];

        // Reset state, including while reset is asserted
        #2;
        check_all("reset_hold");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain("reset_idle", 2);

        // Single word 8'hCC
        words = new[1];
        words[0] = 8'hCC;
        send_words("single", words);
        drain("single_tail", FL + 3);

        // Back-to-back A5, 3C with valid held high
        words = new[2];
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        send_words("b2b", words);
        drain("b2b_tail", 2 * FL + 3);

        // Backpressure: three words offered while idle
        words = new[3];
        words[0] = 8'h96;
        words[1] = 8'h5A;
        words[2] = 8'hE1;
        send_words("bp", words);
        drain("bp_tail", 3 * FL + 3);

        // Reset mid-frame with a word parked in hold
        cycle("rst_mid", 1'b1, 8'hFF);
        cycle("rst_mid", 1'b1, 8'h81);
        cycle("rst_mid", 1'b0, 8'h00);
        check_all("rst_mid_pre");
        rst = 1'b1;
        #1;
        q.delete();
        check_all("rst_mid_async");
        @(posedge clk);
        @(negedge clk);
        check_all("rst_mid_held");
        rst = 1'b0;
        drain("rst_mid_release", 2);
        words = new[1];
        words[0] = 8'h0F;
        send_words("after_rst", words);
        drain("after_rst_tail", FL + 3);

        // Parity-focused words (parity bits 1 then 0 when enabled)
        words = new[2];
        words[0] = 8'h07;
        words[1] = 8'h03;
        send_words("parity", words);
        drain("parity_tail", 2 * FL + 3);

        // Random stream with random valid density
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 3) != 0), 8'($urandom));
        end
        drain("rand_tail", 3 * FL + 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
